// File: rtl/riscv_prefetch_fifo_buffer_pkg.sv
// Shared types for the instruction prefetch buffer.
//   prefetch_entry_t : one buffered fetch result (instruction word,
//                      word address, fetch-error tag).
//   word_addr()      : byte address -> 30-bit word address.
package riscv_prefetch_fifo_buffer_pkg;

  typedef struct packed {
    logic [31:0] rdata;
    logic [29:0] addr;
    logic        err;
  } prefetch_entry_t;

  function automatic logic [29:0] word_addr(input logic [31:0] byte_addr);
    return byte_addr[31:2];
  endfunction

endpackage

// File: rtl/riscv_prefetch_fifo_buffer_mem.sv
// riscv_prefetch_fifo_mem: DEPTH-entry synchronous FIFO of prefetch entries.
//   clk, rst_n : clock, synchronous active-low reset
//   push_i     : write data_i (ignored when full unless popping)
//   data_i     : entry to write
//   pop_i      : drop the head entry (ignored when empty)
//   flush_i    : empty the FIFO; takes priority over push/pop
//   data_o     : head entry (undefined while empty)
//   count_o    : number of stored entries
//   full_o     : count_o == DEPTH
//   empty_o    : count_o == 0
module riscv_prefetch_fifo_mem
  import riscv_prefetch_fifo_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  prefetch_entry_t            data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output prefetch_entry_t            data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  prefetch_entry_t mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;
  logic            do_push, do_pop;

  always_comb begin
    full_o   = (count_q == CW'(DEPTH));
    empty_o  = (count_q == '0);
    do_push  = push_i & (~full_o | pop_i);
    do_pop   = pop_i & ~empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is only observed while non-empty
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/riscv_prefetch_fifo_buffer.sv
// riscv_prefetch_fifo_buffer: instruction prefetch buffer between IF and
// the instruction memory port. Fetches sequential words with up to
// MAX_OUTSTANDING pipelined requests into a DEPTH-entry FIFO; a branch
// flushes the FIFO and discards responses still in flight.
//   clk, rst_n      : clock, synchronous active-low reset
//   req_i           : fetch enable (pending requests still complete)
//   branch_i        : redirect to branch_addr_i and flush
//   branch_addr_i   : branch target (bits [1:0] ignored)
//   ready_i         : IF consumes the head entry
//   valid_o/rdata_o/addr_o/err_o : head entry
//   instr_req_o/instr_addr_o/instr_gnt_i : request channel
//   instr_rvalid_i/instr_rdata_i/instr_err_i : in-order response channel
//   busy_o          : requests in flight or a request being issued
module riscv_prefetch_fifo_buffer
  import riscv_prefetch_fifo_buffer_pkg::*;
#(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic [31:0] addr_o,
  output logic        err_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  output logic        busy_o
);

  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [OW-1:0]   outstanding_q, outstanding_d;
  logic [OW-1:0]   discard_q,     discard_d;
  logic [29:0]     fetch_addr_q,  fetch_addr_d;
  logic [29:0]     resp_addr_q,   resp_addr_d;
  logic            err_lock_q,    err_lock_d;
  logic            started_q,     started_d;

  logic [29:0]     target, issue_word;
  logic [CW-1:0]   fifo_count, count_eff;
  logic            fifo_empty, unused_fifo_full;
  logic            credit, grant, drop, push, pop;
  prefetch_entry_t push_entry, head;
  logic            unused_addr_lsb;

  assign unused_addr_lsb = ^branch_addr_i[1:0];

  always_comb begin
    target     = word_addr(branch_addr_i);
    issue_word = branch_i ? target : fetch_addr_q;
    // The FIFO is flushed by a branch, so its contents earn no credit then
    count_eff  = branch_i ? '0 : fifo_count;
    credit     = (32'(outstanding_q) < MAX_OUTSTANDING) &&
                 (32'(count_eff) + 32'(outstanding_q) < DEPTH);
    instr_req_o  = req_i & (started_q | branch_i) & ~(err_lock_q & ~branch_i) & credit;
    instr_addr_o = {issue_word, 2'b00};
    grant = instr_req_o & instr_gnt_i;
    drop  = instr_rvalid_i & (discard_q != '0);
    // A response arriving in the branch cycle is from the old stream
    push  = instr_rvalid_i & ~drop & ~branch_i;
    pop   = valid_o & ready_i & ~branch_i;

    push_entry = '{rdata: instr_rdata_i, addr: resp_addr_q, err: instr_err_i};

    outstanding_d = outstanding_q + OW'(grant) - OW'(instr_rvalid_i);

    // Everything in flight before the branch is stale; a grant in the
    // branch cycle belongs to the new target and is kept.
    if (branch_i)  discard_d = outstanding_q - OW'(instr_rvalid_i);
    else if (drop) discard_d = discard_q - OW'(1);
    else           discard_d = discard_q;

    if (grant)         fetch_addr_d = issue_word + 30'd1;
    else if (branch_i) fetch_addr_d = target;
    else               fetch_addr_d = fetch_addr_q;

    if (branch_i)  resp_addr_d = target;
    else if (push) resp_addr_d = resp_addr_q + 30'd1;
    else           resp_addr_d = resp_addr_q;

    if (branch_i)                 err_lock_d = 1'b0;
    else if (push && instr_err_i) err_lock_d = 1'b1;
    else                          err_lock_d = err_lock_q;

    started_d = started_q | branch_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outstanding_q <= '0;
      discard_q     <= '0;
      fetch_addr_q  <= '0;
      resp_addr_q   <= '0;
      err_lock_q    <= 1'b0;
      started_q     <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      fetch_addr_q  <= fetch_addr_d;
      resp_addr_q   <= resp_addr_d;
      err_lock_q    <= err_lock_d;
      started_q     <= started_d;
    end
  end

  riscv_prefetch_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .flush_i (branch_i),
    .data_o  (head),
    .count_o (fifo_count),
    .full_o  (unused_fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    valid_o = ~fifo_empty;
    rdata_o = valid_o ? head.rdata : '0;
    addr_o  = valid_o ? {head.addr, 2'b00} : '0;
    err_o   = valid_o & head.err;
    busy_o  = (outstanding_q != '0) | instr_req_o;
  end

  a_rvalid_needs_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
    instr_rvalid_i |-> (outstanding_q != '0));
  a_gnt_needs_req: assert property (@(posedge clk) disable iff (!rst_n)
    instr_gnt_i |-> instr_req_o);

endmodule

// File: tb/tb_riscv_prefetch_fifo_buffer.sv
module tb_riscv_prefetch_fifo_buffer;

  logic        clk = 1'b0;
  logic        rst_n, req_i, branch_i, ready_i;
  logic [31:0] branch_addr_i;
  logic        valid_o, err_o, instr_req_o, busy_o;
  logic [31:0] rdata_o, addr_o, instr_addr_o;
  logic        instr_gnt_i, instr_rvalid_i, instr_err_i;
  logic [31:0] instr_rdata_i;

  always #5 clk = ~clk;

  riscv_prefetch_fifo_buffer #(
    .DEPTH           (4),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_i          (req_i),
    .branch_i       (branch_i),
    .branch_addr_i  (branch_addr_i),
    .ready_i        (ready_i),
    .valid_o        (valid_o),
    .rdata_o        (rdata_o),
    .addr_o         (addr_o),
    .err_o          (err_o),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .instr_err_i    (instr_err_i),
    .busy_o         (busy_o)
  );

  // One clock cycle: inputs held for the cycle, outputs expected during it
  typedef struct packed {
    logic        rst;
    logic        req;
    logic        br;
    logic [31:0] baddr;
    logic        rdy;
    logic        gnt;
    logic        rv;
    logic [31:0] rva;   // address whose word is returned on this response
    logic        er;
    logic        ev;
    logic [31:0] ea;
    logic        ee;
    logic        ereq;
    logic [31:0] eia;
    logic        ebusy;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int vec_no = 0;
  vec_t tbl[$];

  function automatic logic [31:0] dat(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  function automatic vec_t mk(input logic rst, input logic req, input logic br,
                              input logic [31:0] baddr, input logic rdy, input logic gnt,
                              input logic rv, input logic [31:0] rva, input logic er,
                              input logic ev, input logic [31:0] ea, input logic ee,
                              input logic ereq, input logic [31:0] eia, input logic ebusy);
    vec_t v;
    v.rst = rst; v.req = req; v.br = br; v.baddr = baddr; v.rdy = rdy;
    v.gnt = gnt; v.rv = rv; v.rva = rva; v.er = er;
    v.ev = ev; v.ea = ea; v.ee = ee; v.ereq = ereq; v.eia = eia; v.ebusy = ebusy;
    return v;
  endfunction

  task automatic step(input string tag, input vec_t v);
    logic [31:0] exp_a, exp_d;
    logic        exp_e, chk_ia, bad;
    @(posedge clk);
    #1;
    rst_n          = v.rst;
    req_i          = v.req;
    branch_i       = v.br;
    branch_addr_i  = v.baddr;
    ready_i        = v.rdy;
    instr_gnt_i    = v.gnt;
    instr_rvalid_i = v.rv;
    instr_rdata_i  = dat(v.rva);
    instr_err_i    = v.er;
    @(negedge clk);
    exp_a  = v.ev ? v.ea : 32'h0;
    exp_d  = v.ev ? dat(v.ea) : 32'h0;
    exp_e  = v.ev & v.ee;
    chk_ia = v.ereq | ~v.rst;
    bad = (valid_o !== v.ev) || (addr_o !== exp_a) || (rdata_o !== exp_d) ||
          (err_o !== exp_e) || (instr_req_o !== v.ereq) || (busy_o !== v.ebusy) ||
          (chk_ia && (instr_addr_o !== v.eia));
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s #%0d got v=%b a=%h d=%h e=%b req=%b ia=%h busy=%b want v=%b a=%h d=%h e=%b req=%b ia=%h busy=%b",
               tag, vec_no, valid_o, addr_o, rdata_o, err_o, instr_req_o, instr_addr_o, busy_o,
               v.ev, exp_a, exp_d, exp_e, v.ereq, v.eia, v.ebusy);
    end
    vec_no++;
  endtask

  localparam logic [31:0] B = 32'h1C00_8080;

  initial begin
    rst_n = 1'b0; req_i = 1'b0; branch_i = 1'b0; branch_addr_i = '0; ready_i = 1'b0;
    instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = '0; instr_err_i = 1'b0;

    // reset state, then no request before the first branch
    tbl.push_back(mk(0,1,0,0,0,0,0,0,0,        0,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,0,1,0,0,0,0,        0,0,0,0,0,0));
    // streaming from 0x1C008080, one word per cycle, then req_i drops
    tbl.push_back(mk(1,1,1,B,1,1,0,0,0,        0,0,0,1,B,1));
    tbl.push_back(mk(1,1,0,0,1,1,1,B,0,        0,0,0,1,B+4,1));
    tbl.push_back(mk(1,1,0,0,1,1,1,B+4,0,      1,B,0,1,B+8,1));
    tbl.push_back(mk(1,1,0,0,1,1,1,B+8,0,      1,B+4,0,1,B+12,1));
    tbl.push_back(mk(1,1,0,0,1,1,1,B+12,0,     1,B+8,0,1,B+16,1));
    tbl.push_back(mk(1,0,0,0,1,0,1,B+16,0,     1,B+12,0,0,0,1));
    tbl.push_back(mk(1,0,0,0,1,0,0,0,0,        1,B+16,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,1,0,0,0,0,        0,0,0,0,0,0));
    // 0x100/0x104 in flight, branch to 0x200, stale responses dropped
    tbl.push_back(mk(1,1,1,'h100,1,1,0,0,0,    0,0,0,1,'h100,1));
    tbl.push_back(mk(1,1,0,0,1,1,0,0,0,        0,0,0,1,'h104,1));
    tbl.push_back(mk(1,1,1,'h200,1,0,0,0,0,    0,0,0,0,0,1));
    tbl.push_back(mk(1,1,0,0,1,0,1,'h100,0,    0,0,0,0,0,1));
    tbl.push_back(mk(1,1,0,0,1,1,1,'h104,0,    0,0,0,1,'h200,1));
    tbl.push_back(mk(1,1,0,0,1,0,1,'h200,0,    0,0,0,1,'h204,1));
    tbl.push_back(mk(1,0,0,0,1,0,0,0,0,        1,'h200,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,1,0,0,0,0,        0,0,0,0,0,0));

    repeat (2) @(posedge clk);
    for (int i = 0; i < tbl.size(); i++) step("tbl", tbl[i]);

    // credit limit with ready_i=0: four grants, then one pop buys one request
    step("credit", mk(1,1,1,'h300,0,1,0,0,0,   0,0,0,1,'h300,1));
    step("credit", mk(1,1,0,0,0,1,1,'h300,0,   0,0,0,1,'h304,1));
    step("credit", mk(1,1,0,0,0,1,1,'h304,0,   1,'h300,0,1,'h308,1));
    step("credit", mk(1,1,0,0,0,1,1,'h308,0,   1,'h300,0,1,'h30C,1));
    step("credit", mk(1,1,0,0,0,0,1,'h30C,0,   1,'h300,0,0,0,1));
    step("credit", mk(1,1,0,0,1,0,0,0,0,       1,'h300,0,0,0,0));
    step("credit", mk(1,1,0,0,0,1,0,0,0,       1,'h304,0,1,'h310,1));
    step("credit", mk(1,1,0,0,0,0,1,'h310,0,   1,'h304,0,0,0,1));
    step("credit", mk(1,1,0,0,0,0,0,0,0,       1,'h304,0,0,0,0));

    // branch coinciding with rvalid and grant: branch word kept, stale dropped
    step("brsame", mk(1,1,1,'h400,1,1,0,0,0,   1,'h304,0,1,'h400,1));
    step("brsame", mk(1,1,0,0,1,1,1,'h400,0,   0,0,0,1,'h404,1));
    step("brsame", mk(1,1,1,'h500,1,1,1,'h404,0, 1,'h400,0,1,'h500,1));
    step("brsame", mk(1,1,0,0,1,0,1,'h500,0,   0,0,0,1,'h504,1));
    step("brsame", mk(1,0,0,0,1,0,0,0,0,       1,'h500,0,0,0,0));
    step("brsame", mk(1,0,0,0,1,0,0,0,0,       0,0,0,0,0,0));

    // fetch error locks issue until the next branch
    step("errlock", mk(1,1,1,'h40,0,1,0,0,0,   0,0,0,1,'h40,1));
    step("errlock", mk(1,1,0,0,0,1,1,'h40,1,   0,0,0,1,'h44,1));
    step("errlock", mk(1,1,0,0,0,0,1,'h44,0,   1,'h40,1,0,0,1));
    step("errlock", mk(1,1,0,0,0,0,0,0,0,      1,'h40,1,0,0,0));
    step("errlock", mk(1,1,0,0,1,0,0,0,0,      1,'h40,1,0,0,0));
    step("errlock", mk(1,1,0,0,0,0,0,0,0,      1,'h44,0,0,0,0));
    step("errlock", mk(1,1,1,'h80,0,1,0,0,0,   1,'h44,0,1,'h80,1));
    step("errlock", mk(1,1,0,0,0,0,1,'h80,0,   0,0,0,1,'h84,1));
    step("errlock", mk(1,0,0,0,1,0,0,0,0,      1,'h80,0,0,0,0));

    // req_i dropped with two outstanding: both buffered, busy_o falls after
    step("reqdrop", mk(1,1,1,'h600,1,1,0,0,0,  0,0,0,1,'h600,1));
    step("reqdrop", mk(1,1,0,0,1,1,0,0,0,      0,0,0,1,'h604,1));
    step("reqdrop", mk(1,0,0,0,1,0,1,'h600,0,  0,0,0,0,0,1));
    step("reqdrop", mk(1,0,0,0,1,0,1,'h604,0,  1,'h600,0,0,0,1));
    step("reqdrop", mk(1,0,0,0,1,0,0,0,0,      1,'h604,0,0,0,0));
    step("reqdrop", mk(1,0,0,0,1,0,0,0,0,      0,0,0,0,0,0));

    // reset while a request is pending
    step("midrst", mk(1,1,1,'h700,1,1,0,0,0,   0,0,0,1,'h700,1));
    step("midrst", mk(0,1,0,0,1,0,0,0,0,       0,0,0,1,'h704,1));
    step("midrst", mk(0,1,0,0,1,0,0,0,0,       0,0,0,0,0,0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
